pixel_stream_framer: RTL and testbench
======================================

PIXEL_STREAM_FRAMER -- requirements
Module: pixel_stream_framer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 512, pixels per line.
REQ-002 Parameter IMAGE_HEIGHT, default 512, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, output buffer entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 frame_start  input  1  one-cycle pulse arming capture of one frame.
REQ-007 pixel_valid_in  input  1  connects to image_processor pixel_valid_out.
REQ-008 pixel_in  input  24  connects to image_processor pixel_out, RGB 8:8:8.
REQ-009 m_ready  input  1  downstream consumer ready.
REQ-010 m_valid  output  1  m_data and tags valid.
REQ-011 m_data  output  24  buffered pixel.
REQ-012 m_sof  output  1  first pixel of frame (x=0, y=0).
REQ-013 m_eol  output  1  last pixel of a line (x=IMAGE_WIDTH-1).
REQ-014 m_eof  output  1  last pixel of frame.
REQ-015 busy  output  1  high in ACTIVE or DRAIN.
REQ-016 overflow  output  1  sticky: a pixel was dropped this frame.
REQ-017 frame_done  output  1  one-cycle pulse on return to IDLE.

Function
REQ-018 FSM states IDLE, ACTIVE, DRAIN; reset state IDLE.
REQ-019 IDLE -> ACTIVE on frame_start; the same edge clears x, y, overflow.
REQ-020 frame_start in ACTIVE or DRAIN is ignored.
REQ-021 In ACTIVE, each cycle with pixel_valid_in=1 presents pixel_in with tags computed from the current x/y; x increments, wrapping to 0 at IMAGE_WIDTH-1 with y incrementing.
REQ-022 The edge accepting the pixel at x=IMAGE_WIDTH-1, y=IMAGE_HEIGHT-1 moves ACTIVE -> DRAIN.
REQ-023 pixel_valid_in in IDLE or DRAIN is ignored; nothing is written.
REQ-024 FIFO write occurs when not full, or when full and a read occurs in the same cycle (m_valid & m_ready).
REQ-025 A pixel arriving while full with no same-cycle read is dropped, sets overflow, and still advances x/y.
REQ-026 Output is a transfer when m_valid & m_ready; outputs hold stable while m_valid=1 and m_ready=0.
REQ-027 Latency: a pixel written at edge N is visible on m_valid/m_data at edge N+1 if the FIFO was empty.
REQ-028 Empty FIFO: m_valid=0; m_data and tags hold their last value.
REQ-029 DRAIN -> IDLE on the edge the FIFO becomes empty (or the first edge in DRAIN if already empty); frame_done pulses for the following cycle.
REQ-030 Storage width is 27 bits (24 data + sof/eol/eof); data passes unmodified.

Reset
REQ-031 rst=0 asynchronously forces: state IDLE, FIFO empty, x=y=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, busy=0, overflow=0, frame_done=0.
REQ-032 Reset mid-frame discards buffered pixels; no partial-frame tags are emitted after release.
REQ-033 After rst rises, the first frame_start is accepted on the next edge.

Structure
REQ-034 Shared package img_pkg holds PIXEL_W=24, default IMAGE_WIDTH/IMAGE_HEIGHT, the FSM state enum, and the 27-bit tagged-pixel type.
REQ-035 Buffering lives in one sub-module, sync_fifo: parameterised width and depth, first-word-fall-through, with full and empty flags.
REQ-036 Counters x and y are sized $clog2(IMAGE_WIDTH) and $clog2(IMAGE_HEIGHT).

Verification
REQ-037 W=4, H=2, m_ready=1, frame_start, then 8 back-to-back pixels 000001..000008 -> same 8 values out, 1-cycle latency; sof only on 000001; eol on 000004 and 000008; eof only on 000008; frame_done 1 cycle after last transfer.
REQ-038 W=4, H=2, m_ready=0, FIFO_DEPTH=4, 6 pixels -> m_valid=1 holding 000001, overflow=1, pixels 5-6 dropped; m_ready=1 -> exactly 000001..000004 out.
REQ-039 Full FIFO, pixel_valid_in and m_ready both 1 in the same cycle -> new pixel accepted, overflow stays 0.
REQ-040 Pixels with no frame_start, or during DRAIN -> no output, x/y unchanged, busy=0 in IDLE.
REQ-041 rst=0 after 3 of 8 pixels -> m_valid=0 immediately; after release, a new frame produces sof on its first pixel.
REQ-042 512x512 grayscale frame from image_processor with random m_ready -> 262144 transfers, no overflow, output order equals input order.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the pixel streaming path: pixel width, default
// image geometry, framer FSM states and the tagged-pixel storage word.
package img_pkg;

    localparam int PIXEL_W          = 24;
    localparam int DEF_IMAGE_WIDTH  = 512;
    localparam int DEF_IMAGE_HEIGHT = 512;
    localparam int TAGGED_W         = PIXEL_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } framer_state_e;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               sof;
        logic               eol;
        logic               eof;
    } tagged_pixel_t;

    // Counter width that stays legal for a dimension of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic tagged_pixel_t make_tagged(
        input logic [PIXEL_W-1:0] data,
        input logic               sof,
        input logic               eol,
        input logic               eof
    );
        tagged_pixel_t t;
        t.data = data;
        t.sof  = sof;
        t.eol  = eol;
        t.eof  = eof;
        return t;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head word is held in a register so the
// read port is glitch-free and keeps its last value once the FIFO empties.
module sync_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_wr_s, do_rd_s, bypass_s;

    // Next pointers, occupancy and head word for this edge.
    always_comb begin
        do_rd_s  = rd_en_i && (count_q != ZERO_CNT);
        do_wr_s  = wr_en_i && ((count_q != FULL_CNT) || do_rd_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (do_wr_s && !do_rd_s) begin
            count_d = count_q + ONE_CNT;
        end else if (!do_wr_s && do_rd_s) begin
            count_d = count_q - ONE_CNT;
        end else begin
            count_d = count_q;
        end

        // The word being written is the new head when nothing older remains.
        bypass_s = do_wr_s && ((count_q == ZERO_CNT) || ((count_q == ONE_CNT) && do_rd_s));

        if (count_d == ZERO_CNT) begin
            head_d = head_q;
        end else if (bypass_s) begin
            head_d = wr_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= ZERO_CNT;
            head_q   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = head_q;
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == ZERO_CNT);
    assign count_o   = count_q;

endmodule

// File: rtl/pixel_stream_framer.sv
// Captures one frame of pixels per frame_start, tags frame/line boundaries
// and buffers the tagged stream towards a ready/valid consumer.
module pixel_stream_framer
    import img_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pixel_valid_in,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [PIXEL_W-1:0] m_data,
    output logic               m_sof,
    output logic               m_eol,
    output logic               m_eof,
    output logic               busy,
    output logic               overflow,
    output logic               frame_done
);

    localparam int             XW      = cnt_width(IMAGE_WIDTH);
    localparam int             YW      = cnt_width(IMAGE_HEIGHT);
    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0]  X_LAST  = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0]  ONE_CNT = CW'(1);

    framer_state_e state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          busy_q;

    logic          sof_s, eol_s, eof_s;
    logic          wr_en_s, rd_en_s;
    logic          full_s, empty_s;
    logic [CW-1:0] count_s;
    tagged_pixel_t wr_tag_s;
    tagged_pixel_t head_s;

    assign rd_en_s = !empty_s && m_ready;

    // Tags describe the position of the pixel currently on pixel_in.
    always_comb begin
        sof_s    = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
        eol_s    = (x_q == X_LAST);
        eof_s    = eol_s && (y_q == Y_LAST);
        wr_tag_s = make_tagged(pixel_in, sof_s, eol_s, eof_s);
    end

    // Frame FSM, position counters and overflow tracking.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        wr_en_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ACTIVE;
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (pixel_valid_in) begin
                    wr_en_s = 1'b1;
                    // A dropped pixel still consumes its x/y slot.
                    if (full_s && !rd_en_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (eol_s) begin
                        x_d = {XW{1'b0}};
                        if (y_q == Y_LAST) begin
                            y_d     = {YW{1'b0}};
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (empty_s || ((count_s == ONE_CNT) && rd_en_s)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    sync_fifo #(
        .WIDTH (TAGGED_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wr_en_s),
        .wr_data_i (wr_tag_s),
        .rd_en_i   (rd_en_s),
        .rd_data_o (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .count_o   (count_s)
    );

    assign m_valid    = !empty_s;
    assign m_data     = head_s.data;
    assign m_sof      = head_s.sof;
    assign m_eol      = head_s.eol;
    assign m_eof      = head_s.eof;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Bench for pixel_stream_framer on a 4x2 image with a 4-entry buffer:
// directed scenarios with literal expectations, then randomized traffic.
module tb_pixel_stream_framer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        pixel_valid_in;
    logic [23:0] pixel_in;
    logic        m_ready;
    logic        m_valid;
    logic [23:0] m_data;
    logic        m_sof, m_eol, m_eof;
    logic        busy, overflow, frame_done;

    int checks = 0;
    int passes = 0;

    pixel_stream_framer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .pixel_valid_in (pixel_valid_in),
        .pixel_in       (pixel_in),
        .m_ready        (m_ready),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_sof          (m_sof),
        .m_eol          (m_eol),
        .m_eof          (m_eof),
        .busy           (busy),
        .overflow       (overflow),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model: queue of tagged words {data,sof,eol,eof}, pixel index n
    // within the frame, mode 0=idle 1=capturing 2=draining.
    logic [26:0] exp_q[$];
    int          mode_m  = 0;
    int          n_m     = 0;
    bit          ovf_m   = 1'b0;
    bit          done_m  = 1'b0;
    logic [26:0] shown_m = 27'd0;

    always @(posedge clk or negedge rst) begin : model_p
        bit          xfer;
        logic [26:0] item;
        if (!rst) begin
            exp_q.delete();
            mode_m  = 0;
            n_m     = 0;
            ovf_m   = 1'b0;
            done_m  = 1'b0;
            shown_m = 27'd0;
        end else begin
            xfer   = (exp_q.size() > 0) && m_ready;
            done_m = 1'b0;
            if (xfer) void'(exp_q.pop_front());
            if (mode_m == 0) begin
                if (frame_start) begin
                    mode_m = 1;
                    n_m    = 0;
                    ovf_m  = 1'b0;
                end
            end else if (mode_m == 1) begin
                if (pixel_valid_in) begin
                    item = {pixel_in, 1'(n_m == 0), 1'((n_m % W) == W - 1), 1'(n_m == W * H - 1)};
                    if (exp_q.size() < D) exp_q.push_back(item);
                    else ovf_m = 1'b1;
                    n_m++;
                    if (n_m == W * H) mode_m = 2;
                end
            end else begin
                if (exp_q.size() == 0) begin
                    mode_m = 0;
                    done_m = 1'b1;
                end
            end
            if (exp_q.size() > 0) shown_m = exp_q[0];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
        chk("head", 32'({m_data, m_sof, m_eol, m_eof}), 32'(shown_m));
        chk("busy", 32'(busy), 32'(mode_m != 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("frame_done", 32'(frame_done), 32'(done_m));
    end

    task automatic drive(input logic fs, input logic pv, input logic [23:0] pix, input logic rdy);
        frame_start    = fs;
        pixel_valid_in = pv;
        pixel_in       = pix;
        m_ready        = rdy;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rnd;
        int          rdy_pct;
        rst = 1'b0;
        frame_start = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_in = 24'd0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Back-to-back frame, consumer always ready.
        drive(1'b1, 1'b0, 24'd0, 1'b1);
        chk("arm_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 24'(i), 1'b1);
            chk("bb_data", 32'(m_data), 32'(i));
            chk("bb_sof", 32'(m_sof), 32'(i == 1));
            chk("bb_eol", 32'(m_eol), 32'((i == 4) || (i == 8)));
            chk("bb_eof", 32'(m_eof), 32'(i == 8));
        end
        drive(1'b0, 1'b0, 24'd0, 1'b1);
        chk("bb_done", 32'(frame_done), 32'd1);
        chk("bb_valid_end", 32'(m_valid), 32'd0);
        drive(1'b0, 1'b0, 24'd0, 1'b1);
        chk("bb_done_pulse", 32'(frame_done), 32'd0);
        chk("bb_hold", 32'(m_data), 32'h000008);

        // Stalled consumer: buffer fills, pixels 5 and 6 are lost.
        drive(1'b1, 1'b0, 24'd0, 1'b0);
        for (int i = 1; i <= 6; i++) drive(1'b0, 1'b1, 24'(i), 1'b0);
        chk("ovf_hold_data", 32'(m_data), 32'h000001);
        chk("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            drive(1'b0, 1'b0, 24'd0, 1'b1);
            chk("ovf_drain", 32'(m_data), 32'(k));
        end
        drive(1'b0, 1'b0, 24'd0, 1'b1);
        chk("ovf_empty", 32'(m_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        drive(1'b0, 1'b1, 24'd7, 1'b1);
        chk("ovf_p7_eol", 32'(m_eol), 32'd0);
        drive(1'b0, 1'b1, 24'd8, 1'b1);
        chk("ovf_p8_eof", 32'(m_eof), 32'd1);
        drive(1'b0, 1'b0, 24'd0, 1'b1);
        drive(1'b0, 1'b0, 24'd0, 1'b1);

        // Full buffer with a simultaneous read accepts the new pixel.
        drive(1'b1, 1'b0, 24'd0, 1'b0);
        for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 24'(i), 1'b0);
        drive(1'b0, 1'b1, 24'd5, 1'b1);
        chk("full_rw_ovf", 32'(overflow), 32'd0);
        chk("full_rw_head", 32'(m_data), 32'h000002);
        for (int i = 6; i <= 8; i++) drive(1'b0, 1'b1, 24'(i), 1'b1);
        repeat (6) drive(1'b0, 1'b0, 24'd0, 1'b1);

        // Pixels while idle and while draining are ignored.
        repeat (3) drive(1'b0, 1'b1, 24'hABCDEF, 1'b1);
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        drive(1'b1, 1'b0, 24'd0, 1'b1);
        for (int i = 1; i <= 7; i++) drive(1'b0, 1'b1, 24'(i), 1'b1);
        drive(1'b0, 1'b1, 24'd8, 1'b0);
        drive(1'b0, 1'b1, 24'h000099, 1'b0);
        drive(1'b1, 1'b0, 24'd0, 1'b0);
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_head", 32'(m_data), 32'h000007);
        drive(1'b0, 1'b0, 24'd0, 1'b1);
        drive(1'b0, 1'b0, 24'd0, 1'b1);
        chk("drain_done", 32'(frame_done), 32'd1);
        chk("drain_last", 32'(m_data), 32'h000008);
        drive(1'b1, 1'b0, 24'd0, 1'b1);
        drive(1'b0, 1'b1, 24'h123456, 1'b1);
        chk("after_drain_sof", 32'(m_sof), 32'd1);
        for (int i = 2; i <= 8; i++) drive(1'b0, 1'b1, 24'(i), 1'b1);
        repeat (3) drive(1'b0, 1'b0, 24'd0, 1'b1);

        // Reset in the middle of a frame.
        drive(1'b1, 1'b0, 24'd0, 1'b0);
        drive(1'b0, 1'b1, 24'h000011, 1'b0);
        drive(1'b0, 1'b1, 24'h000022, 1'b0);
        drive(1'b0, 1'b1, 24'h000033, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_data", 32'(m_data), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 24'h000044, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 24'd0, 1'b1);
        drive(1'b0, 1'b1, 24'h000055, 1'b1);
        chk("midrst_sof", 32'(m_sof), 32'd1);
        chk("midrst_new", 32'(m_data), 32'h000055);
        for (int i = 2; i <= 8; i++) drive(1'b0, 1'b1, 24'(i), 1'b1);
        repeat (3) drive(1'b0, 1'b0, 24'd0, 1'b1);

        // Randomized traffic with varying consumer throughput.
        for (int c = 0; c < 3000; c++) begin
            rdy_pct = ((c / 500) % 3 == 0) ? 90 : (((c / 500) % 3 == 1) ? 50 : 15);
            rnd = $urandom;
            drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7),
                  rnd[23:0], 1'($urandom_range(0, 99) < rdy_pct));
        end
        repeat (40) drive(1'b0, 1'b0, 24'd0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
